barrel_unshifter_seq: RTL and testbench

Sequential 4-bit right shifter/rotator: the inverse of the combinational left barrel shifter. It takes a shifted nibble and an amount from the dedicated inputs. It then moves the nibble right one bit position per clock under a small FSM, and reports busy/done/valid status on the dedicated outputs. It is a TinyTapeout top-level tile (`tt_um_ankur_gupta_29_barrel_unshifter_seq`), wired pin-for-pin in the same convention as the shifter tile, so the two chips can be chained off-board.

---
 rtl/barrel_unshifter_seq.sv | 88 ++++++++
 tb/tb_barrel_unshifter_seq.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/barrel_unshifter_seq.sv
// Sequential 4-bit right rotator/shifter tile: undoes the left barrel shifter one bit per clock.
// Start is a rising edge of ui_in[7]; status appears on uo_out[6:4].
module barrel_unshifter_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e     state_q, state_d;
    logic [3:0] data_q, data_d;
    logic [1:0] cnt_q, cnt_d;
    logic       mode_q, mode_d;
    logic       start_q;
    logic       done_q, done_d;
    logic       valid_q, valid_d;
    logic       start_ev;
    logic       busy;

    // ena and the bidirectional inputs carry no function on this tile.
    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in};

    assign start_ev = ui_in[7] & ~start_q;
    assign busy     = (state_q == StRun);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        unique case (state_q)
            StIdle: begin
                if (start_ev) begin
                    data_d  = ui_in[3:0];
                    cnt_d   = ui_in[5:4];
                    mode_d  = ui_in[6];
                    valid_d = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (cnt_q != 2'd0) begin
                    // mode 1 zero-fills the top bit, mode 0 wraps bit 0 around.
                    data_d = {(mode_q ? 1'b0 : data_q[0]), data_q[3:1]};
                    cnt_d  = cnt_q - 2'd1;
                end else begin
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            data_q  <= 4'd0;
            cnt_q   <= 2'd0;
            mode_q  <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            start_q <= ui_in[7];
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

    assign uo_out  = {1'b0, valid_q, done_q, busy, data_q};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_barrel_unshifter_seq.sv
// Self-checking bench for barrel_unshifter_seq: directed cases plus random stimulus
// compared cycle by cycle against an operation-level reference model.
module tb_barrel_unshifter_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena = 1'b1;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    barrel_unshifter_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: an accepted op keeps busy for amt+1 edges, then posts its result.
    int         m_left;
    logic [3:0] m_res;
    logic       m_valid;
    logic       m_done;
    logic       m_start_q;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_unshift(input logic [3:0] d, input int amt, input logic mode);
        int v;
        v = d;
        if (mode) return 4'(v >> amt);
        return 4'(((v >> amt) | (v << (4 - amt))) & 15);
    endfunction

    task automatic model_reset();
        m_left    = 0;
        m_res     = 4'd0;
        m_valid   = 1'b0;
        m_done    = 1'b0;
        m_start_q = 1'b0;
    endtask

    task automatic model_edge(input logic [7:0] ui);
        m_done = 1'b0;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done  = 1'b1;
                m_valid = 1'b1;
            end
        end else if (ui[7] && !m_start_q) begin
            m_left  = int'(ui[5:4]) + 1;
            m_valid = 1'b0;
            m_res   = ref_unshift(ui[3:0], int'(ui[5:4]), ui[6]);
        end
        m_start_q = ui[7];
    endtask

    // Drive inputs, take one clock edge, then compare status (and result when valid).
    task automatic step(input logic [7:0] ui);
        ui_in = ui;
        @(posedge clk);
        #1;
        model_edge(ui);
        check_eq("status", {4'd0, uo_out[7:4]},
                 {5'd0, m_valid, m_done, (m_left > 0)});
        if (m_valid) check_eq("result", {4'd0, uo_out[3:0]}, {4'd0, m_res});
    endtask

    task automatic run_op(input logic [3:0] d, input logic [1:0] amt, input logic mode);
        step({1'b1, mode, amt, d});
        for (int i = 0; i <= int'(amt); i++) step({1'b0, mode, amt, d});
    endtask

    int done_cnt;

    initial begin
        rst_n = 1'b0;
        ui_in = 8'h00;
        model_reset();
        #1;
        check_eq("reset_uo_out", uo_out, 8'h00);
        check_eq("uio_out", uio_out, 8'h00);
        check_eq("uio_oe", uio_oe, 8'h00);

        // Release reset with start already high: first edge is a start event.
        ui_in = 8'b1_0_01_1001;
        #6 rst_n = 1'b1;
        step(8'b1_0_01_1001);
        step(8'b0_0_01_1001);
        step(8'b0_0_01_1001);
        check_eq("start_at_reset", uo_out, 8'h6C);
        step(8'h00);

        run_op(4'b1001, 2'd1, 1'b0);
        check_eq("rot_1001_by1", uo_out, 8'h6C);
        step(8'h00);
        check_eq("done_one_cycle", uo_out, 8'h4C);

        run_op(4'b1011, 2'd3, 1'b1);
        check_eq("shr_1011_by3", uo_out, 8'h61);

        run_op(4'b0110, 2'd0, 1'b0);
        check_eq("amt0_0110", uo_out, 8'h66);

        // A fresh start mid-RUN is ignored.
        step(8'b1_0_11_0001);
        step(8'b0_0_11_0001);
        step(8'b1_1_00_1111);
        step(8'b0_1_00_1111);
        step(8'b0_1_00_1111);
        check_eq("ignored_restart", uo_out, 8'h62);
        for (int i = 0; i < 3; i++) step(8'h00);
        check_eq("no_second_op", uo_out, 8'h42);

        // Held start level triggers exactly one operation.
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(8'b1_0_10_0101);
            if (uo_out[5]) done_cnt++;
        end
        check_eq("held_done_cnt", 8'(done_cnt), 8'd1);
        check_eq("held_result", uo_out, 8'h45);
        step(8'h00);

        // Asynchronous reset in the middle of a run.
        step(8'b1_0_11_1000);
        step(8'b0_0_11_1000);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_reset", uo_out, 8'h00);
        model_reset();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(8'b0_0_11_1000);
        check_eq("idle_after_reset", uo_out, 8'h00);

        for (int i = 0; i < 400; i++) begin
            logic [7:0] r;
            r    = 8'($urandom);
            r[7] = ($urandom_range(0, 2) == 0);
            step(r);
        end
        for (int i = 0; i < 5; i++) step(8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
